aes_decrypt_iter: RTL

Iterative, handshaked AES-128 decryption engine. It replaces the fully unrolled, fixed-key decryptor with a round-folded datapath that runs `UNROLL` inverse rounds per clock. The round-key schedule is computed on-chip into a round-key register file from a runtime-loadable key. The block sits between the ciphertext source and the plaintext consumer, with valid/ready handshakes on key, input and output.

---
 rtl/aes_pkg.sv | 87 ++++++++
 rtl/aes_inv_round.sv | 37 +++
 rtl/aes_decrypt_iter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, S-box/Rcon tables and round helper functions
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Entry 0 is unused so the table can be indexed directly by round number.
    localparam logic [7:0] RCON [0:AES_NR] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
    endfunction

    function automatic aes_state_t keystep(input aes_state_t prev, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = prev;
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t round_key,
    input  logic       last,
    output aes_state_t result
);

    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t keyed;

    // Byte n sits at row n%4, column n/4; row r rotates right by r columns.
    always_comb begin
        shifted = '0;
        subbed  = '0;
        keyed   = '0;
        result  = '0;
        for (int n = 0; n < 16; n++) begin
            shifted[127-8*n -: 8] = state[127-8*((((n/4) - (n%4) + 4) % 4) * 4 + (n%4)) -: 8];
        end
        for (int n = 0; n < 16; n++) begin
            subbed[127-8*n -: 8] = INV_SBOX[shifted[127-8*n -: 8]];
        end
        keyed = subbed ^ round_key;
        if (last) begin
            result = keyed;
        end else begin
            for (int j = 0; j < 4; j++) begin
                result[127-32*j -: 32] = inv_mix_col(keyed[127-32*j -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative handshaked AES-128 decryptor; AES_DEC_KEYLOAD_EN enables runtime key loading
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int          UNROLL      = 1,
    parameter logic [127:0] DEFAULT_KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic         busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes_decrypt_iter: UNROLL must be 1, 2, 5 or 10");
    end

    localparam logic [1:0] ST_KEXP  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] FIRST_R = 4'(AES_NR - 1);
    localparam logic [3:0] LAST_R  = 4'(UNROLL - 1);
    localparam logic [3:0] STEP_R  = 4'(UNROLL);
    localparam logic [3:0] LAST_K  = 4'(AES_NR);

    logic [1:0]  state;
    logic [3:0]  k;
    logic [3:0]  r;
    aes_state_t  st;
    aes_state_t  rk [0:AES_NR];
    aes_state_t  chain [0:UNROLL];
    logic        key_req;
    logic        key_accept;
    logic        blk_accept;

`ifdef AES_DEC_KEYLOAD_EN
    assign key_req   = key_valid;
    assign key_ready = (state == ST_IDLE);
`else
    logic unused_key;
    assign unused_key = key_valid;
    assign key_req    = 1'b0;
    assign key_ready  = 1'b0;
`endif

    // A pending key always wins over a pending block, so the schedule never changes mid-block.
    assign in_ready   = ((state == ST_IDLE) || (state == ST_DONE && out_ready)) && !key_req;
    assign key_accept = key_ready && key_req;
    assign blk_accept = in_valid && in_ready;
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    assign chain[0] = st;

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        logic [3:0] ri;
        assign ri = r - 4'(i);
        aes_inv_round u_inv_round (
            .state     (chain[i]),
            .round_key (rk[ri]),
            .last      (ri == 4'd0),
            .result    (chain[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_KEXP;
            k        <= 4'd1;
            r        <= FIRST_R;
            st       <= '0;
            out_data <= '0;
            rk[0]    <= DEFAULT_KEY;
            for (int i = 1; i <= AES_NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            case (state)
                ST_KEXP: begin
                    rk[k] <= keystep(rk[k - 4'd1], RCON[k]);
                    if (k == LAST_K) begin
                        state <= ST_IDLE;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (key_accept) begin
                        rk[0] <= key_in;
                        k     <= 4'd1;
                        state <= ST_KEXP;
                    end else if (blk_accept) begin
                        st    <= in_data ^ rk[AES_NR];
                        r     <= FIRST_R;
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (r == LAST_R) begin
                        out_data <= chain[UNROLL];
                        state    <= ST_DONE;
                    end else begin
                        st <= chain[UNROLL];
                        r  <= r - STEP_R;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (blk_accept) begin
                            st    <= in_data ^ rk[AES_NR];
                            r     <= FIRST_R;
                            state <= ST_ROUND;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
